mc_control_fsm: RTL and testbench

Multicycle main controller that sequences instructions and drives the ALU: it is the initiator on the aluControl/zero interface.
- Decodes op/funct from the instruction register.
- Steps a Moore FSM through fetch/decode/execute/memory/writeback.
- Issues per-state datapath enables and ALU commands.
- Consumes the ALU zero flag for branches.
- Sits between the instruction register and the multicycle datapath (PC, memory, register file, ALU muxes).

---
 rtl/mc_control_fsm_pkg.sv | 64 ++++++
 rtl/mc_control_fsm_alu_decoder.sv | 40 ++++
 rtl/mc_control_fsm.sv | 182 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// mc_pkg: shared constants for the multicycle main controller.
//   - opcode and R-type funct encodings of the supported instruction subset
//   - aluControl codes, matching the ALU (000 add, 001 sub, 010 and, 011 or, 100 slt)
//   - aluOp codes driven into alu_decoder
//   - aluSrcB and pcSrc mux encodings
//   - FSM state encoding, which is also visible on the debug port 'state'
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // True for the opcodes that are always supported (bne is handled separately
  // because it depends on the build configuration; R-type also needs funct).
  function automatic logic op_is_base_legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// alu_decoder: combinational ALU command decoder.
//   i_alu_op[1:0]      00 = add, 01 = sub, 10 = take operation from funct
//   i_funct[5:0]       R-type funct field
//   o_alu_control[2:0] ALU command (000 add, 001 sub, 010 and, 011 or, 100 slt)
//   o_funct_valid      funct is one of the supported R-type functions;
//                      independent of i_alu_op so DECODE can check legality
//                      while the ALU is still commanded to add
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_funct_valid
);

  logic [2:0] w_funct_op;

  always_comb begin
    w_funct_op    = ALU_ADD;
    o_funct_valid = 1'b1;
    case (i_funct)
      FN_ADD:  w_funct_op = ALU_ADD;
      FN_SUB:  w_funct_op = ALU_SUB;
      FN_AND:  w_funct_op = ALU_AND;
      FN_OR:   w_funct_op = ALU_OR;
      FN_SLT:  w_funct_op = ALU_SLT;
      default: o_funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    case (i_alu_op)
      ALUOP_SUB:   o_alu_control = ALU_SUB;
      ALUOP_FUNCT: o_alu_control = w_funct_op;
      default:     o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore main controller of a multicycle MIPS-style datapath.
// Build option: define MC_BNE_EN to accept bne (op 000101).
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   op, funct           IR[31:26] and IR[5:0]
//   zero                ALU zero flag
//   pcEn irWrite memWrite regWrite   datapath write enables (0 during reset)
//   iorD regDst memtoReg aluSrcA aluSrcB pcSrc   datapath mux selects
//   aluControl          ALU command
//   state               current state code (debug)
//   illegal             unsupported op/funct seen in DECODE
// ALU contract: this block is the initiator. aluControl is driven every cycle
// from the current state; zero is only consumed in BRANCH, in the same cycle
// the sub command is issued, and ignored everywhere else.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcEn,
  output logic       irWrite,
  output logic       memWrite,
  output logic       regWrite,
  output logic       iorD,
  output logic       regDst,
  output logic       memtoReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic [2:0] aluControl,
  output logic [3:0] state,
  output logic       illegal
);

  state_t     r_state;
  logic [1:0] w_alu_op;
  logic       w_funct_valid;
  logic       w_decode_ok;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_branch_cond;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;

`ifdef MC_BNE_EN
  logic r_is_bne;
  assign w_decode_ok   = op_is_base_legal(op) || (op == OP_BNE) ||
                         ((op == OP_RTYPE) && w_funct_valid);
  assign w_branch_cond = r_is_bne ? ~zero : zero;
`else
  assign w_decode_ok   = op_is_base_legal(op) ||
                         ((op == OP_RTYPE) && w_funct_valid);
  assign w_branch_cond = zero;
`endif

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct       (funct),
    .o_alu_control (aluControl),
    .o_funct_valid (w_funct_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
`ifdef MC_BNE_EN
      r_is_bne <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
`ifdef MC_BNE_EN
          r_is_bne <= (op == OP_BNE);
`endif
          if (!w_decode_ok) begin
            r_state <= S_FETCH;
          end else begin
            case (op)
              OP_LW, OP_SW: r_state <= S_MEMADR;
              OP_RTYPE:     r_state <= S_EXEC;
              OP_BEQ:       r_state <= S_BRANCH;
`ifdef MC_BNE_EN
              OP_BNE:       r_state <= S_BRANCH;
`endif
              OP_ADDI:      r_state <= S_ADDIEX;
              OP_J:         r_state <= S_JUMP;
              default:      r_state <= S_FETCH;
            endcase
          end
        end
        // Only lw and sw reach MEMADR, so anything but sw is a load.
        S_MEMADR: r_state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  r_state <= S_MEMWB;
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the registered state; only pcEn (branch) and illegal
  // additionally look at live inputs.
  always_comb begin
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    iorD        = 1'b0;
    regDst      = 1'b0;
    memtoReg    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_REGB;
    pcSrc       = PCSRC_ALU;
    w_alu_op    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        aluSrcB    = SRCB_FOUR;
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
      end
      S_DECODE: begin
        aluSrcB   = SRCB_IMM_SH2;
        w_illegal = ~w_decode_ok;
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMRD: iorD = 1'b1;
      S_MEMWB: begin
        memtoReg    = 1'b1;
        w_reg_write = 1'b1;
      end
      S_MEMWR: begin
        iorD        = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXEC: begin
        aluSrcA  = 1'b1;
        w_alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regDst      = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA  = 1'b1;
        w_alu_op = ALUOP_SUB;
        pcSrc    = PCSRC_ALUOUT;
        w_branch = 1'b1;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        pcSrc      = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are masked by reset so an instruction aborted by reset cannot
  // write anything in the reset cycle itself.
  assign pcEn     = ~reset & (w_pc_write | (w_branch & w_branch_cond));
  assign irWrite  = ~reset & w_ir_write;
  assign memWrite = ~reset & w_mem_write;
  assign regWrite = ~reset & w_reg_write;
  assign illegal  = ~reset & w_illegal;
  assign state    = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

`ifdef MC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcEn, irWrite, memWrite, regWrite, iorD, regDst, memtoReg, aluSrcA;
  logic [1:0] aluSrcB, pcSrc;
  logic [2:0] aluControl;
  logic [3:0] state;
  logic       illegal;

  int tests = 0;
  int fails = 0;

  // Expected per-cycle entry: {branch kind (0 none, 1 beq, 2 bne), state, outputs}
  logic [21:0] exp_q[$];

  logic [5:0] funct_codes [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] alu_codes   [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcEn(pcEn), .irWrite(irWrite), .memWrite(memWrite), .regWrite(regWrite),
    .iorD(iorD), .regDst(regDst), .memtoReg(memtoReg), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .pcSrc(pcSrc), .aluControl(aluControl),
    .state(state), .illegal(illegal)
  );

  // clock block
  always #5 clk = ~clk;

  wire [15:0] obs_vec = {pcEn, irWrite, memWrite, regWrite, illegal, iorD, regDst,
                         memtoReg, aluSrcA, aluSrcB, pcSrc, aluControl};

  function automatic logic [15:0] ov(
    input logic pcen, input logic irw, input logic memw, input logic regw,
    input logic ill, input logic iord, input logic regdst, input logic memtoreg,
    input logic srca, input logic [1:0] srcb, input logic [1:0] pcsrc,
    input logic [2:0] aluc);
    return {pcen, irw, memw, regw, ill, iord, regdst, memtoreg, srca, srcb, pcsrc, aluc};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [1:0] br, input logic [3:0] st, input logic [15:0] v);
    exp_q.push_back({br, st, v});
  endtask

  // Reference model: expected cycle-by-cycle trace of one instruction,
  // written as the instruction's step list.
  task automatic build(input logic [5:0] o, input logic [5:0] f);
    logic       fok;
    logic [2:0] ac;
    logic       legal;
    fok = 1'b0;
    ac  = 3'b000;
    for (int i = 0; i < 5; i++)
      if (f == funct_codes[i]) begin
        fok = 1'b1;
        ac  = alu_codes[i];
      end
    legal = (o == 6'd35) || (o == 6'd43) || (o == 6'd4) || (o == 6'd8) ||
            (o == 6'd2) || ((o == 6'd0) && fok) || (BNE_EN && (o == 6'd5));
    push(2'd0, 4'd0, ov(1,1,0,0,0, 0,0,0, 0,2'b01,2'b00,3'b000));
    push(2'd0, 4'd1, ov(0,0,0,0,!legal, 0,0,0, 0,2'b11,2'b00,3'b000));
    if (legal) begin
      case (o)
        6'd35: begin
          push(2'd0, 4'd2, ov(0,0,0,0,0, 0,0,0, 1,2'b10,2'b00,3'b000));
          push(2'd0, 4'd3, ov(0,0,0,0,0, 1,0,0, 0,2'b00,2'b00,3'b000));
          push(2'd0, 4'd4, ov(0,0,0,1,0, 0,0,1, 0,2'b00,2'b00,3'b000));
        end
        6'd43: begin
          push(2'd0, 4'd2, ov(0,0,0,0,0, 0,0,0, 1,2'b10,2'b00,3'b000));
          push(2'd0, 4'd5, ov(0,0,1,0,0, 1,0,0, 0,2'b00,2'b00,3'b000));
        end
        6'd0: begin
          push(2'd0, 4'd6, ov(0,0,0,0,0, 0,0,0, 1,2'b00,2'b00,ac));
          push(2'd0, 4'd7, ov(0,0,0,1,0, 0,1,0, 0,2'b00,2'b00,3'b000));
        end
        6'd4: push(2'd1, 4'd8, ov(0,0,0,0,0, 0,0,0, 1,2'b00,2'b01,3'b001));
        6'd5: push(2'd2, 4'd8, ov(0,0,0,0,0, 0,0,0, 1,2'b00,2'b01,3'b001));
        6'd8: begin
          push(2'd0, 4'd9, ov(0,0,0,0,0, 0,0,0, 1,2'b10,2'b00,3'b000));
          push(2'd0, 4'd10, ov(0,0,0,1,0, 0,0,0, 0,2'b00,2'b00,3'b000));
        end
        default: push(2'd0, 4'd11, ov(1,0,0,0,0, 0,0,0, 0,2'b00,2'b10,3'b000));
      endcase
    end
  endtask

  // Driver: zmode 0/1 holds zero at that value, 2 randomises it every cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
    logic [21:0] e;
    logic [15:0] ev;
    op    = o;
    funct = f;
    build(o, f);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      @(negedge clk);
      ev = e[15:0];
      if (e[21:20] == 2'd1) ev[15] = zero;
      else if (e[21:20] == 2'd2) ev[15] = ~zero;
      chk($sformatf("state op=%b funct=%b", o, f), {12'd0, state}, {12'd0, e[19:16]});
      chk($sformatf("outputs op=%b funct=%b st=%0d", o, f, e[19:16]), obs_vec, ev);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] ro, rf;
    int sel;
    reset = 1'b1;
    op    = 6'd0;
    funct = 6'd0;
    zero  = 1'b0;

    // Reset state and enable masking.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {12'd0, state}, 16'd0);
    chk("reset_enables", {11'd0, pcEn, irWrite, memWrite, regWrite, illegal}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Walk a sw into MEMWR, then reset it there for 2 cycles.
    op = 6'b101011;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("memwr_reached", {12'd0, state}, 16'd5);
    chk("memwr_write", {15'd0, memWrite}, 16'd1);
    reset = 1'b1;
    #1;
    chk("reset_masks_memwrite", {15'd0, memWrite}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    chk("reset_to_fetch", {12'd0, state}, 16'd0);
    chk("reset_enables_fetch", {11'd0, pcEn, irWrite, memWrite, regWrite, illegal}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed instructions (first FETCH checks irWrite=1/pcEn=1 after reset).
    run_instr(6'b101011, 6'd0, 2);        // sw
    run_instr(6'b100011, 6'd0, 2);        // lw
    run_instr(6'b000000, 6'b101010, 2);   // slt
    run_instr(6'b000100, 6'd0, 1);        // beq taken
    run_instr(6'b000100, 6'd0, 0);        // beq not taken
    run_instr(6'b111111, 6'd0, 2);        // illegal op
    run_instr(6'b000000, 6'b000111, 2);   // illegal funct
    run_instr(6'b000101, 6'd0, 0);        // bne, not equal
    run_instr(6'b000101, 6'd0, 1);        // bne, equal
    run_instr(6'b001000, 6'd0, 2);        // addi
    run_instr(6'b000010, 6'd0, 2);        // j

    // Randomised instruction stream.
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 8);
      rf  = 6'($urandom_range(0, 63));
      case (sel)
        0: ro = 6'b100011;
        1: ro = 6'b101011;
        2: begin ro = 6'b000000; rf = funct_codes[$urandom_range(0, 4)]; end
        3: ro = 6'b000100;
        4: ro = 6'b001000;
        5: ro = 6'b000010;
        6: ro = 6'b000101;
        7: ro = 6'($urandom_range(0, 63));
        default: ro = 6'b000000;
      endcase
      run_instr(ro, rf, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
